// File: rtl/spi_flash_loader_if.sv
// Flash pins and memory write port of the boot ROM loader.
// The loader drives the master side; the flash and memory models sit on the slave side.
interface spi_flash_loader_if;
    logic        flash_csn;
    logic        flash_sck;
    logic        flash_mosi;
    logic        flash_miso;
    logic [21:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        wr_busy;
    logic        load_done;

    modport master (
        output flash_csn, flash_sck, flash_mosi, wr_addr, wr_data, wr_en, load_done,
        input  flash_miso, wr_busy
    );

    modport slave (
        input  flash_csn, flash_sck, flash_mosi, wr_addr, wr_data, wr_en, load_done,
        output flash_miso, wr_busy
    );
endinterface

// File: rtl/spi_flash_loader.sv
// Boot-time loader: wakes the SPI flash (0xAB), then one continuous READ (0x03)
// streams LOAD_BYTES bytes into the memory write port and raises load_done.
module spi_flash_loader #(
    parameter logic [23:0] FLASH_OFFSET = 24'h100000,
    parameter logic [21:0] LOAD_BYTES   = 22'd262144,
    parameter int          SCK_HALF     = 1,
    parameter logic [15:0] WAKE_CYCLES  = 16'd1000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    spi_flash_loader_if.master     bus
);
    localparam int          DW        = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(SCK_HALF - 1);
    localparam logic [31:0] WAKE_WORD = {8'hAB, 24'h000000};
    localparam logic [31:0] READ_WORD = {8'h03, FLASH_OFFSET};

    typedef enum logic [2:0] {
        WAKE_CMD  = 3'd0,
        WAKE_WAIT = 3'd1,
        READ_CMD  = 3'd2,
        READ_BYTE = 3'd3,
        WRITE     = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t        state_r;
    logic [DW-1:0] div_r;
    logic [4:0]    bit_cnt_r;
    logic [31:0]   sh_r;
    logic [7:0]    rx_r;
    logic [15:0]   wait_r;
    logic          csn_r;
    logic          sck_r;
    logic          mosi_r;
    logic [21:0]   wr_addr_r;
    logic [7:0]    wr_data_r;
    logic          wr_en_r;
    logic          done_r;
    logic          tick_s;

    // End of the current SCK half-period.
    always_comb begin
        tick_s = 1'b0;
        if (div_r == DIV_MAX) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Sequencer: SPI shifting, write handshake and all registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= WAKE_CMD;
            div_r     <= '0;
            bit_cnt_r <= 5'd0;
            sh_r      <= 32'd0;
            rx_r      <= 8'd0;
            wait_r    <= 16'd0;
            csn_r     <= 1'b1;
            sck_r     <= 1'b0;
            mosi_r    <= 1'b0;
            wr_addr_r <= 22'd0;
            wr_data_r <= 8'd0;
            wr_en_r   <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                WAKE_CMD: begin
                    if (csn_r) begin
                        csn_r     <= 1'b0;
                        sh_r      <= WAKE_WORD;
                        mosi_r    <= WAKE_WORD[31];
                        div_r     <= '0;
                        bit_cnt_r <= 5'd0;
                    end else if (tick_s) begin
                        div_r <= '0;
                        // bit count 8 is the csn hold tail after the last falling edge
                        if (bit_cnt_r == 5'd8) begin
                            csn_r   <= 1'b1;
                            wait_r  <= 16'd0;
                            state_r <= WAKE_WAIT;
                        end else if (!sck_r) begin
                            sck_r <= 1'b1;
                        end else begin
                            sck_r     <= 1'b0;
                            mosi_r    <= sh_r[30];
                            sh_r      <= {sh_r[30:0], 1'b0};
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end else begin
                        div_r <= div_r + DW'(1);
                    end
                end
                WAKE_WAIT: begin
                    if (wait_r == WAKE_CYCLES - 16'd1) begin
                        csn_r     <= 1'b0;
                        sh_r      <= READ_WORD;
                        mosi_r    <= READ_WORD[31];
                        div_r     <= '0;
                        bit_cnt_r <= 5'd0;
                        state_r   <= READ_CMD;
                    end else begin
                        wait_r <= wait_r + 16'd1;
                    end
                end
                READ_CMD: begin
                    if (tick_s) begin
                        div_r <= '0;
                        if (!sck_r) begin
                            sck_r <= 1'b1;
                        end else begin
                            sck_r  <= 1'b0;
                            mosi_r <= sh_r[30];
                            sh_r   <= {sh_r[30:0], 1'b0};
                            if (bit_cnt_r == 5'd31) begin
                                bit_cnt_r <= 5'd0;
                                state_r   <= READ_BYTE;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 5'd1;
                            end
                        end
                    end else begin
                        div_r <= div_r + DW'(1);
                    end
                end
                READ_BYTE: begin
                    if (tick_s) begin
                        div_r <= '0;
                        if (bit_cnt_r == 5'd8) begin
                            wr_data_r <= rx_r;
                            wr_en_r   <= 1'b1;
                            bit_cnt_r <= 5'd0;
                            state_r   <= WRITE;
                        end else if (!sck_r) begin
                            sck_r <= 1'b1;
                            rx_r  <= {rx_r[6:0], bus.flash_miso};
                        end else begin
                            sck_r     <= 1'b0;
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end else begin
                        div_r <= div_r + DW'(1);
                    end
                end
                WRITE: begin
                    // the flash tolerates an SCK pause, so stalls only stretch this state
                    if (!bus.wr_busy) begin
                        wr_en_r <= 1'b0;
                        div_r   <= '0;
                        if (wr_addr_r == LOAD_BYTES - 22'd1) begin
                            csn_r   <= 1'b1;
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            wr_addr_r <= wr_addr_r + 22'd1;
                            state_r   <= READ_BYTE;
                        end
                    end else begin
                        wr_en_r <= 1'b1;
                    end
                end
                DONE: begin
                    csn_r   <= 1'b1;
                    sck_r   <= 1'b0;
                    wr_en_r <= 1'b0;
                    done_r  <= 1'b1;
                end
                default: begin
                    state_r <= WAKE_CMD;
                    csn_r   <= 1'b1;
                    sck_r   <= 1'b0;
                    wr_en_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.flash_csn  = csn_r;
    assign bus.flash_sck  = sck_r;
    assign bus.flash_mosi = mosi_r;
    assign bus.wr_addr    = wr_addr_r;
    assign bus.wr_data    = wr_data_r;
    assign bus.wr_en      = wr_en_r;
    assign bus.load_done  = done_r;
endmodule
